i2s_fifo_ctrl: RTL and testbench

I2S_FIFO_CTRL -- requirements
Module: i2s_fifo_ctrl

---
 rtl/i2s_fifo_ctrl_if.sv | 62 ++++++
 rtl/i2s_fifo_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_i2s_fifo_ctrl.sv | 485 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2s_fifo_ctrl_if.sv
// Bus- and I2S-side signal bundle for i2s_fifo_ctrl.
// The master side is the bus host and I2S engine; the slave side is the controller.
interface i2s_fifo_ctrl_if #(
  parameter int AW = 3
);
  // Bus write path into the TX FIFO
  logic          tx_wr_en;
  logic [31:0]   tx_wdata;
  // Bus read path out of the RX FIFO
  logic          rx_rd_en;
  logic [31:0]   rx_rdata;
  // Control
  logic          tx_flush;
  logic          rx_flush;
  logic [AW:0]   tx_thresh;
  logic [AW:0]   rx_thresh;
  logic          tx_irq_en;
  logic          rx_irq_en;
  logic          err_irq_en;
  logic          err_clr;
  // Status
  logic [AW:0]   tx_level;
  logic [AW:0]   rx_level;
  logic          tx_full;
  logic          tx_empty;
  logic          rx_full;
  logic          rx_empty;
  logic          tx_wr_err;
  logic          rx_rd_err;
  logic          underrun_sts;
  logic          overrun_sts;
  logic          irq;
  // I2S stream side
  logic [31:0]   i2s_data_in;
  logic          i2s_data_in_valid;
  logic          i2s_data_in_ack;
  logic [31:0]   i2s_data_out;
  logic          i2s_data_out_valid;
  logic          i2s_data_out_ack;
  logic          i2s_tx_underrun;
  logic          i2s_rx_overrun;

  modport master (
    output tx_wr_en, tx_wdata, rx_rd_en, tx_flush, rx_flush,
    output tx_thresh, rx_thresh, tx_irq_en, rx_irq_en, err_irq_en, err_clr,
    output i2s_data_in_ack, i2s_data_out, i2s_data_out_valid,
    output i2s_tx_underrun, i2s_rx_overrun,
    input  rx_rdata, tx_level, rx_level, tx_full, tx_empty, rx_full, rx_empty,
    input  tx_wr_err, rx_rd_err, underrun_sts, overrun_sts, irq,
    input  i2s_data_in, i2s_data_in_valid, i2s_data_out_ack
  );

  modport slave (
    input  tx_wr_en, tx_wdata, rx_rd_en, tx_flush, rx_flush,
    input  tx_thresh, rx_thresh, tx_irq_en, rx_irq_en, err_irq_en, err_clr,
    input  i2s_data_in_ack, i2s_data_out, i2s_data_out_valid,
    input  i2s_tx_underrun, i2s_rx_overrun,
    output rx_rdata, tx_level, rx_level, tx_full, tx_empty, rx_full, rx_empty,
    output tx_wr_err, rx_rd_err, underrun_sts, overrun_sts, irq,
    output i2s_data_in, i2s_data_in_valid, i2s_data_out_ack
  );
endinterface

// File: rtl/i2s_fifo_ctrl.sv
// TX/RX sample FIFOs between a register bus and an I2S serialiser, with
// sticky error flags and a registered level/error interrupt.
module i2s_fifo_ctrl #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  i2s_fifo_ctrl_if.slave   bus
);

  localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] LVL_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  // ---------------------------------------------------------------- TX FIFO
  logic [31:0]   tx_mem [DEPTH];
  logic [AW-1:0] tx_wr_ptr;
  logic [AW-1:0] tx_rd_ptr;
  logic [AW:0]   tx_level;
  logic [AW:0]   tx_level_nxt;
  logic          tx_full_q;
  logic          tx_empty_q;
  logic          tx_push;
  logic          tx_pop;

  assign tx_push = bus.tx_wr_en & ~tx_full_q;
  assign tx_pop  = bus.i2s_data_in_ack & ~tx_empty_q;

  always_comb begin
    // NOTE: default assignment first, so every path drives the signal and no latch is inferred.
    tx_level_nxt = tx_level;
    if (tx_push && !tx_pop)
      tx_level_nxt = tx_level + LVL_ONE;
    else if (tx_pop && !tx_push)
      tx_level_nxt = tx_level - LVL_ONE;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_wr_ptr  <= '0;
      tx_rd_ptr  <= '0;
      tx_level   <= '0;
      tx_full_q  <= 1'b0;
      tx_empty_q <= 1'b1;
    end else if (bus.tx_flush) begin
      tx_wr_ptr  <= '0;
      tx_rd_ptr  <= '0;
      tx_level   <= '0;
      tx_full_q  <= 1'b0;
      tx_empty_q <= 1'b1;
    end else begin
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + PTR_ONE;
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + PTR_ONE;
      tx_level   <= tx_level_nxt;
      tx_full_q  <= (tx_level_nxt == LVL_FULL);
      tx_empty_q <= (tx_level_nxt == '0);
    end
  end

  // NOTE: storage arrays carry no reset; pointers and level alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (tx_push && !bus.tx_flush)
      tx_mem[tx_wr_ptr] <= bus.tx_wdata;
  end

  assign bus.i2s_data_in       = tx_mem[tx_rd_ptr];
  assign bus.i2s_data_in_valid = ~tx_empty_q;
  assign bus.tx_level          = tx_level;
  assign bus.tx_full           = tx_full_q;
  assign bus.tx_empty          = tx_empty_q;

  // ---------------------------------------------------------------- RX FIFO
  logic [31:0]   rx_mem [DEPTH];
  logic [AW-1:0] rx_wr_ptr;
  logic [AW-1:0] rx_rd_ptr;
  logic [AW:0]   rx_level;
  logic [AW:0]   rx_level_nxt;
  logic          rx_full_q;
  logic          rx_empty_q;
  logic          rx_hold;
  logic          rx_push;
  logic          rx_pop;

  // A held valid after an accepted word is the same sample; wait for it to drop.
  assign rx_push = bus.i2s_data_out_valid & ~rx_full_q & ~rx_hold;
  assign rx_pop  = bus.rx_rd_en & ~rx_empty_q;

  always_comb begin
    rx_level_nxt = rx_level;
    if (rx_push && !rx_pop)
      rx_level_nxt = rx_level + LVL_ONE;
    else if (rx_pop && !rx_push)
      rx_level_nxt = rx_level - LVL_ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_wr_ptr  <= '0;
      rx_rd_ptr  <= '0;
      rx_level   <= '0;
      rx_full_q  <= 1'b0;
      rx_empty_q <= 1'b1;
    end else if (bus.rx_flush) begin
      rx_wr_ptr  <= '0;
      rx_rd_ptr  <= '0;
      rx_level   <= '0;
      rx_full_q  <= 1'b0;
      rx_empty_q <= 1'b1;
    end else begin
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + PTR_ONE;
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + PTR_ONE;
      rx_level   <= rx_level_nxt;
      rx_full_q  <= (rx_level_nxt == LVL_FULL);
      rx_empty_q <= (rx_level_nxt == '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      rx_hold <= 1'b0;
    else if (rx_push)
      rx_hold <= 1'b1;
    else if (!bus.i2s_data_out_valid)
      rx_hold <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rx_push && !bus.rx_flush)
      rx_mem[rx_wr_ptr] <= bus.i2s_data_out;
  end

  assign bus.i2s_data_out_ack = rx_push;
  assign bus.rx_rdata         = rx_empty_q ? 32'h0 : rx_mem[rx_rd_ptr];
  assign bus.rx_level         = rx_level;
  assign bus.rx_full          = rx_full_q;
  assign bus.rx_empty         = rx_empty_q;

  // ---------------------------------------------------------- sticky errors
  logic tx_wr_err_q;
  logic rx_rd_err_q;
  logic underrun_q;
  logic overrun_q;

  // A new error event in the same cycle as err_clr keeps the bit set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_wr_err_q <= 1'b0;
      rx_rd_err_q <= 1'b0;
      underrun_q  <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      tx_wr_err_q <= (bus.tx_wr_en & tx_full_q)  | (tx_wr_err_q & ~bus.err_clr);
      rx_rd_err_q <= (bus.rx_rd_en & rx_empty_q) | (rx_rd_err_q & ~bus.err_clr);
      underrun_q  <= bus.i2s_tx_underrun          | (underrun_q  & ~bus.err_clr);
      overrun_q   <= bus.i2s_rx_overrun           | (overrun_q   & ~bus.err_clr);
    end
  end

  assign bus.tx_wr_err    = tx_wr_err_q;
  assign bus.rx_rd_err    = rx_rd_err_q;
  assign bus.underrun_sts = underrun_q;
  assign bus.overrun_sts  = overrun_q;

  // -------------------------------------------------------------- interrupt
  logic tx_req;
  logic rx_req;
  logic err_req;
  logic irq_q;

  assign tx_req  = bus.tx_irq_en & (tx_level <= bus.tx_thresh);
  assign rx_req  = bus.rx_irq_en & (rx_level >= bus.rx_thresh) & (bus.rx_thresh != '0);
  assign err_req = bus.err_irq_en & (tx_wr_err_q | rx_rd_err_q | underrun_q | overrun_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      irq_q <= 1'b0;
    else
      irq_q <= tx_req | rx_req | err_req;
  end

  assign bus.irq = irq_q;

endmodule

// File: tb/tb_i2s_fifo_ctrl.sv
// Self-checking bench for i2s_fifo_ctrl: queue scoreboards for TX and RX data,
// a small level model, and one task per scenario.
module tb_i2s_fifo_ctrl;

  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [31:0] tx_q[$];
  logic [31:0] rx_q[$];
  int          m_tx_level = 0;
  int          m_rx_level = 0;

  i2s_fifo_ctrl_if #(.AW(AW)) bus ();

  i2s_fifo_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.tx_wr_en           = 1'b0;
    bus.tx_wdata           = '0;
    bus.rx_rd_en           = 1'b0;
    bus.tx_flush           = 1'b0;
    bus.rx_flush           = 1'b0;
    bus.tx_thresh          = '0;
    bus.rx_thresh          = '0;
    bus.tx_irq_en          = 1'b0;
    bus.rx_irq_en          = 1'b0;
    bus.err_irq_en         = 1'b0;
    bus.err_clr            = 1'b0;
    bus.i2s_data_in_ack    = 1'b0;
    bus.i2s_data_out       = '0;
    bus.i2s_data_out_valid = 1'b0;
    bus.i2s_tx_underrun    = 1'b0;
    bus.i2s_rx_overrun     = 1'b0;
  endtask

  // Stimulus only: one bus write, scoreboard updated from the bench's own model.
  task automatic tx_write(input logic [31:0] data);
    bus.tx_wr_en = 1'b1;
    bus.tx_wdata = data;
    if (m_tx_level < DEPTH) begin
      tx_q.push_back(data);
      m_tx_level++;
    end
    tick();
    bus.tx_wr_en = 1'b0;
  endtask

  // Stimulus only: one I2S sample held for one cycle, then a gap cycle.
  task automatic rx_send(input logic [31:0] data);
    bus.i2s_data_out_valid = 1'b1;
    bus.i2s_data_out       = data;
    if (m_rx_level < DEPTH) begin
      rx_q.push_back(data);
      m_rx_level++;
    end
    tick();
    bus.i2s_data_out_valid = 1'b0;
    tick();
  endtask

  task automatic clear_errors();
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
  endtask

  function automatic logic [18:0] status_vec();
    return {bus.tx_level, bus.rx_level, bus.tx_full, bus.tx_empty, bus.rx_full,
            bus.rx_empty, bus.i2s_data_in_valid, bus.tx_wr_err, bus.rx_rd_err,
            bus.underrun_sts, bus.overrun_sts, bus.irq};
  endfunction

  localparam logic [18:0] RESET_STATUS = {4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'b0};

  task automatic test_reset();
    logic [18:0] st;
    idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    st = status_vec();
    checks++;
    if (st !== RESET_STATUS) begin
      errors++;
      $display("FAIL reset_status: got %b want %b", st, RESET_STATUS);
    end
    checks++;
    if (bus.rx_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_rx_rdata: got %h want 00000000", bus.rx_rdata);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_tx_fill_drain();
    for (int i = 1; i <= 8; i++) tx_write(32'(i));
    checks++;
    if (bus.tx_full !== 1'b1 || bus.tx_level !== 4'(m_tx_level)) begin
      errors++;
      $display("FAIL tx_fill: full=%b level=%0d want full=1 level=%0d",
               bus.tx_full, bus.tx_level, m_tx_level);
    end
    tx_write(32'h9);
    checks++;
    if (bus.tx_wr_err !== 1'b1 || bus.tx_level !== 4'd8) begin
      errors++;
      $display("FAIL tx_write_when_full: wr_err=%b level=%0d want wr_err=1 level=8",
               bus.tx_wr_err, bus.tx_level);
    end
    bus.i2s_data_in_ack = 1'b1;
    for (int i = 0; i < 8; i++) begin
      logic [31:0] exp;
      #1;
      exp = tx_q.pop_front();
      m_tx_level--;
      checks++;
      if (bus.i2s_data_in_valid !== 1'b1 || bus.i2s_data_in !== exp) begin
        errors++;
        $display("FAIL tx_drain_%0d: valid=%b data=%h want valid=1 data=%h",
                 i, bus.i2s_data_in_valid, bus.i2s_data_in, exp);
      end
      tick();
    end
    bus.i2s_data_in_ack = 1'b0;
    checks++;
    if (bus.tx_empty !== 1'b1 || bus.i2s_data_in_valid !== 1'b0 || bus.tx_level !== 4'd0) begin
      errors++;
      $display("FAIL tx_drained: empty=%b valid=%b level=%0d want 1 0 0",
               bus.tx_empty, bus.i2s_data_in_valid, bus.tx_level);
    end
    clear_errors();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) tx_write(32'h10 + 32'(i));
    bus.tx_wr_en        = 1'b1;
    bus.i2s_data_in_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      logic [31:0] exp;
      bus.tx_wdata = 32'h20 + 32'(i);
      #1;
      exp = tx_q.pop_front();
      tx_q.push_back(bus.tx_wdata);
      checks++;
      if (bus.i2s_data_in !== exp) begin
        errors++;
        $display("FAIL b2b_head_%0d: got %h want %h", i, bus.i2s_data_in, exp);
      end
      tick();
      checks++;
      if (bus.tx_level !== 4'(m_tx_level)) begin
        errors++;
        $display("FAIL b2b_level_%0d: got %0d want %0d", i, bus.tx_level, m_tx_level);
      end
    end
    bus.tx_wr_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      logic [31:0] exp;
      #1;
      exp = tx_q.pop_front();
      m_tx_level--;
      checks++;
      if (bus.i2s_data_in !== exp) begin
        errors++;
        $display("FAIL b2b_drain_%0d: got %h want %h", i, bus.i2s_data_in, exp);
      end
      tick();
    end
    bus.i2s_data_in_ack = 1'b0;
  endtask

  task automatic test_rx_fill_overrun();
    // First sample: valid held two cycles must be pushed only once.
    bus.i2s_data_out_valid = 1'b1;
    bus.i2s_data_out       = 32'hA0;
    #1;
    checks++;
    if (bus.i2s_data_out_ack !== 1'b1) begin
      errors++;
      $display("FAIL rx_ack_first: got %b want 1", bus.i2s_data_out_ack);
    end
    rx_q.push_back(32'hA0);
    m_rx_level++;
    tick();
    checks++;
    if (bus.i2s_data_out_ack !== 1'b0) begin
      errors++;
      $display("FAIL rx_ack_held_valid: got %b want 0", bus.i2s_data_out_ack);
    end
    tick();
    bus.i2s_data_out_valid = 1'b0;
    checks++;
    if (bus.rx_level !== 4'd1) begin
      errors++;
      $display("FAIL rx_single_push: level=%0d want 1", bus.rx_level);
    end
    tick();
    for (int i = 1; i < 9; i++) begin
      logic exp_ack;
      bus.i2s_data_out_valid = 1'b1;
      bus.i2s_data_out       = 32'hA0 + 32'(i);
      #1;
      exp_ack = (m_rx_level < DEPTH);
      checks++;
      if (bus.i2s_data_out_ack !== exp_ack) begin
        errors++;
        $display("FAIL rx_ack_%0d: got %b want %b", i, bus.i2s_data_out_ack, exp_ack);
      end
      if (exp_ack) begin
        rx_q.push_back(bus.i2s_data_out);
        m_rx_level++;
      end
      tick();
      bus.i2s_data_out_valid = 1'b0;
      tick();
    end
    checks++;
    if (bus.rx_full !== 1'b1 || bus.rx_level !== 4'd8) begin
      errors++;
      $display("FAIL rx_full: full=%b level=%0d want 1 8", bus.rx_full, bus.rx_level);
    end
    bus.err_irq_en     = 1'b1;
    bus.i2s_rx_overrun = 1'b1;
    tick();
    bus.i2s_rx_overrun = 1'b0;
    checks++;
    if (bus.overrun_sts !== 1'b1 || bus.irq !== 1'b0) begin
      errors++;
      $display("FAIL overrun_set: sts=%b irq=%b want 1 0", bus.overrun_sts, bus.irq);
    end
    tick();
    checks++;
    if (bus.irq !== 1'b1) begin
      errors++;
      $display("FAIL overrun_irq: got %b want 1", bus.irq);
    end
    bus.rx_rd_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      logic [31:0] exp;
      #1;
      exp = rx_q.pop_front();
      m_rx_level--;
      checks++;
      if (bus.rx_rdata !== exp) begin
        errors++;
        $display("FAIL rx_read_%0d: got %h want %h", i, bus.rx_rdata, exp);
      end
      tick();
    end
    bus.rx_rd_en   = 1'b0;
    bus.err_irq_en = 1'b0;
    checks++;
    if (bus.rx_empty !== 1'b1 || bus.rx_level !== 4'd0) begin
      errors++;
      $display("FAIL rx_drained: empty=%b level=%0d want 1 0", bus.rx_empty, bus.rx_level);
    end
    clear_errors();
    tick();
    checks++;
    if (bus.overrun_sts !== 1'b0 || bus.irq !== 1'b0) begin
      errors++;
      $display("FAIL err_clear: sts=%b irq=%b want 0 0", bus.overrun_sts, bus.irq);
    end
  endtask

  task automatic test_rx_irq();
    bus.rx_thresh = 4'd4;
    bus.rx_irq_en = 1'b1;
    for (int i = 0; i < 3; i++) rx_send(32'hB0 + 32'(i));
    bus.i2s_data_out_valid = 1'b1;
    bus.i2s_data_out       = 32'hB3;
    rx_q.push_back(32'hB3);
    m_rx_level++;
    tick();
    bus.i2s_data_out_valid = 1'b0;
    checks++;
    if (bus.rx_level !== 4'd4 || bus.irq !== 1'b0) begin
      errors++;
      $display("FAIL rx_irq_latency: level=%0d irq=%b want 4 0", bus.rx_level, bus.irq);
    end
    tick();
    checks++;
    if (bus.irq !== 1'b1) begin
      errors++;
      $display("FAIL rx_irq_rise: got %b want 1", bus.irq);
    end
    bus.rx_rd_en = 1'b1;
    #1;
    begin
      logic [31:0] exp;
      exp = rx_q.pop_front();
      m_rx_level--;
      checks++;
      if (bus.rx_rdata !== exp) begin
        errors++;
        $display("FAIL rx_irq_read: got %h want %h", bus.rx_rdata, exp);
      end
    end
    tick();
    bus.rx_rd_en = 1'b0;
    checks++;
    if (bus.rx_level !== 4'd3 || bus.irq !== 1'b1) begin
      errors++;
      $display("FAIL rx_irq_hold: level=%0d irq=%b want 3 1", bus.rx_level, bus.irq);
    end
    tick();
    checks++;
    if (bus.irq !== 1'b0) begin
      errors++;
      $display("FAIL rx_irq_fall: got %b want 0", bus.irq);
    end
    bus.rx_irq_en = 1'b0;
    bus.rx_thresh = '0;
    bus.rx_rd_en  = 1'b1;
    while (m_rx_level > 0) begin
      logic [31:0] exp;
      #1;
      exp = rx_q.pop_front();
      m_rx_level--;
      checks++;
      if (bus.rx_rdata !== exp) begin
        errors++;
        $display("FAIL rx_irq_drain: got %h want %h", bus.rx_rdata, exp);
      end
      tick();
    end
    bus.rx_rd_en = 1'b0;
  endtask

  task automatic test_flush_sticky();
    for (int i = 0; i < 5; i++) tx_write(32'hC0 + 32'(i));
    checks++;
    if (bus.tx_level !== 4'd5) begin
      errors++;
      $display("FAIL flush_prefill: level=%0d want 5", bus.tx_level);
    end
    bus.tx_flush = 1'b1;
    bus.tx_wr_en = 1'b1;
    bus.tx_wdata = 32'hDEAD;
    tick();
    bus.tx_flush = 1'b0;
    bus.tx_wr_en = 1'b0;
    tx_q.delete();
    m_tx_level = 0;
    checks++;
    if (bus.tx_level !== 4'd0 || bus.tx_empty !== 1'b1 || bus.i2s_data_in_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_level: level=%0d empty=%b valid=%b want 0 1 0",
               bus.tx_level, bus.tx_empty, bus.i2s_data_in_valid);
    end
    tx_write(32'h55);
    bus.i2s_data_in_ack = 1'b1;
    #1;
    begin
      logic [31:0] exp;
      exp = tx_q.pop_front();
      m_tx_level--;
      checks++;
      if (bus.i2s_data_in_valid !== 1'b1 || bus.i2s_data_in !== exp) begin
        errors++;
        $display("FAIL flush_then_write: valid=%b data=%h want 1 %h",
                 bus.i2s_data_in_valid, bus.i2s_data_in, exp);
      end
    end
    tick();
    bus.i2s_data_in_ack = 1'b0;
    bus.i2s_tx_underrun = 1'b1;
    bus.err_clr         = 1'b1;
    tick();
    bus.i2s_tx_underrun = 1'b0;
    bus.err_clr         = 1'b0;
    checks++;
    if (bus.underrun_sts !== 1'b1) begin
      errors++;
      $display("FAIL set_beats_clear: underrun_sts=%b want 1", bus.underrun_sts);
    end
    clear_errors();
    checks++;
    if (bus.underrun_sts !== 1'b0) begin
      errors++;
      $display("FAIL underrun_clear: underrun_sts=%b want 0", bus.underrun_sts);
    end
  endtask

  task automatic test_rd_empty_and_reset();
    logic [18:0] st;
    bus.rx_rd_en = 1'b1;
    #1;
    checks++;
    if (bus.rx_rdata !== 32'h0) begin
      errors++;
      $display("FAIL rd_empty_data: got %h want 00000000", bus.rx_rdata);
    end
    tick();
    bus.rx_rd_en = 1'b0;
    checks++;
    if (bus.rx_rd_err !== 1'b1 || bus.rx_level !== 4'd0) begin
      errors++;
      $display("FAIL rd_empty_err: rd_err=%b level=%0d want 1 0", bus.rx_rd_err, bus.rx_level);
    end
    for (int i = 0; i < 3; i++) rx_send(32'hD0 + 32'(i));
    tx_write(32'hE0);
    tx_write(32'hE1);
    checks++;
    if (bus.rx_level !== 4'd3 || bus.tx_level !== 4'd2) begin
      errors++;
      $display("FAIL pre_reset_levels: rx=%0d tx=%0d want 3 2", bus.rx_level, bus.tx_level);
    end
    bus.tx_wr_en = 1'b1;
    bus.tx_wdata = 32'hEE;
    rst_n = 1'b0;
    #1;
    st = status_vec();
    checks++;
    if (st !== RESET_STATUS || bus.rx_rdata !== 32'h0) begin
      errors++;
      $display("FAIL midrun_reset: status=%b rdata=%h want %b 00000000",
               st, bus.rx_rdata, RESET_STATUS);
    end
    bus.tx_wr_en = 1'b0;
    tx_q.delete();
    rx_q.delete();
    m_tx_level = 0;
    m_rx_level = 0;
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (bus.i2s_data_in_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_valid: got %b want 0", bus.i2s_data_in_valid);
    end
    tx_write(32'h77);
    begin
      logic [31:0] exp;
      exp = tx_q.pop_front();
      m_tx_level--;
      checks++;
      if (bus.i2s_data_in_valid !== 1'b1 || bus.i2s_data_in !== exp) begin
        errors++;
        $display("FAIL post_reset_first: valid=%b data=%h want 1 %h",
                 bus.i2s_data_in_valid, bus.i2s_data_in, exp);
      end
    end
  endtask

  initial begin
    idle();
    test_reset();
    test_tx_fill_drain();
    test_back_to_back();
    test_rx_fill_overrun();
    test_rx_irq();
    test_flush_sticky();
    test_rd_empty_and_reset();
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
